lsu_mem_master: RTL and testbench



---
 rtl/lsu_mem_master.sv | 160 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a word-wide data RAM with combinational read data.
// Byte/halfword loads are lane-extracted and extended; sub-word stores use read-modify-write.
module lsu_mem_master #(
    parameter int address_width = 1024,
    parameter int data_width    = 32
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [2:0]                       req_funct3,
    input  logic [31:0]                      req_addr,
    input  logic [31:0]                      req_wdata,
    output logic                             resp_valid,
    output logic [31:0]                      resp_rdata,
    output logic                             resp_err,
    output logic [$clog2(address_width)-1:0] mem_address,
    output logic [data_width-1:0]            mem_write_data,
    output logic                             mem_MemWrite,
    input  logic [data_width-1:0]            mem_read_data
);

    localparam int AW = $clog2(address_width);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [2:0]            lat_funct3;
    logic [AW+1:0]         lat_addr;
    logic [15:0]           lat_wdata;
    logic [data_width-1:0] merged;
    logic                  accept;
    logic                  req_bad;
    logic                  req_is_sw;
    logic [4:0]            lane_shift;
    logic [data_width-1:0] lane_word;
    logic [data_width-1:0] load_data;
    logic [data_width-1:0] lane_mask;
    logic [data_width-1:0] merge_data;
    logic                  unused_addr_bits;

    // Handshake: a request transfers on a rising edge with req_valid & req_ready;
    // req_ready is high only in IDLE, and each accepted request yields exactly one
    // single-cycle resp_valid pulse. There is never more than one request in flight.
    assign accept    = req_valid && req_ready;
    assign req_ready = (state == IDLE);
    assign req_is_sw = req_we && (req_funct3 == 3'b010);

    assign unused_addr_bits = ^req_addr[31:AW+2];

    always_comb begin
        req_bad = 1'b1;
        if (req_we) begin
            case (req_funct3)
                3'b000:  req_bad = 1'b0;
                3'b001:  req_bad = req_addr[0];
                3'b010:  req_bad = |req_addr[1:0];
                default: req_bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_bad = 1'b0;
                3'b001, 3'b101: req_bad = req_addr[0];
                3'b010:         req_bad = |req_addr[1:0];
                default:        req_bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)       state_next = RESP;
                    else if (!req_we)  state_next = LOAD;
                    else if (req_is_sw) state_next = WRITE;
                    else               state_next = MERGE;
                end
            end
            LOAD:    state_next = RESP;
            MERGE:   state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane position in bits; for halfwords lat_addr[0] is already known to be 0.
    assign lane_shift = {lat_addr[1:0], 3'b000};

    always_comb begin
        lane_word = mem_read_data >> lane_shift;
        load_data = mem_read_data;
        case (lat_funct3)
            3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_data = {24'h000000, lane_word[7:0]};
            3'b101:  load_data = {16'h0000, lane_word[15:0]};
            default: load_data = mem_read_data;
        endcase
    end

    always_comb begin
        lane_mask  = (lat_funct3 == 3'b000) ? data_width'(8'hFF) : data_width'(16'hFFFF);
        merge_data = (mem_read_data & ~(lane_mask << lane_shift))
                   | ((data_width'(lat_wdata) & lane_mask) << lane_shift);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            lat_funct3 <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= 16'h0000;
            merged     <= '0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr[AW+1:0];
                lat_wdata  <= req_wdata[15:0];
                if (req_bad) begin
                    resp_rdata <= 32'h0000_0000;
                    resp_err   <= 1'b1;
                end else if (req_is_sw) begin
                    merged <= req_wdata;
                end
            end
            case (state)
                LOAD: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                MERGE: merged <= merge_data;
                WRITE: begin
                    resp_rdata <= 32'h0000_0000;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid     = (state == RESP);
    assign mem_MemWrite   = (state == WRITE);
    assign mem_write_data = merged;
    assign mem_address    = lat_addr[AW+1:2];

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: driver tasks push expected responses into a
// scoreboard queue, a negedge monitor pops and compares each response it sees.
module tb_lsu_mem_master;

    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_MemWrite;
    logic [31:0]   mem_read_data;

    logic [31:0]   ram [0:1023];
    logic          pre_en;
    logic [AW-1:0] pre_idx;
    logic [31:0]   pre_data;

    logic [31:0]   exp_q[$];
    logic          exp_err_q[$];
    int            exp_lat_q[$];
    int            acc_q[$];

    int            cyc = 0;
    int            wr_cnt = 0;
    int            last_acc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    lsu_mem_master #(.address_width(1024), .data_width(32)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_MemWrite   (mem_MemWrite),
        .mem_read_data  (mem_read_data)
    );

    // clock and environment
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign mem_read_data = ram[mem_address];

    always @(posedge CLK) begin
        if (mem_MemWrite) ram[mem_address] <= mem_write_data;
        else if (pre_en)  ram[pre_idx] <= pre_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // scoreboard monitor
    task automatic check_resp();
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        int          a;
        if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
            e_rd  = exp_q.pop_front();
            e_err = exp_err_q.pop_front();
            e_lat = exp_lat_q.pop_front();
            a     = acc_q.pop_front();
            chk("resp_rdata", resp_rdata, e_rd);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
            chk("latency", cyc - a, e_lat);
        end
    endtask

    always @(negedge CLK) begin
        if (mem_MemWrite) wr_cnt <= wr_cnt + 1;
        if (RST_N && resp_valid) check_resp();
    end

    // driver: called at a negedge, returns at the negedge after the accept edge
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input bit hold);
        int waited = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            exp_q.push_back(exp_rd);
            exp_err_q.push_back(exp_err);
            exp_lat_q.push_back(exp_lat);
            acc_q.push_back(cyc);
            last_acc = cyc;
            @(negedge CLK);
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
            exp_err_q.delete();
            exp_lat_q.delete();
            acc_q.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        RST_N      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        pre_en     = 1'b1;
        pre_idx    = 10'd5;
        pre_data   = 32'h8899_AABB;
        repeat (2) @(negedge CLK);
        pre_en = 1'b0;

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_memwrite", {31'd0, mem_MemWrite}, 32'd0);
        chk("rst_mem_address", {22'd0, mem_address}, 32'd0);

        RST_N = 1'b1;
        @(negedge CLK);

        // loads from RAM[5] = 0x8899AABB
        w0 = wr_cnt;
        issue(1'b0, 3'b010, 32'h14, 32'h0, 32'h8899_AABB, 1'b0, 2, 1'b0); wait_done();
        issue(1'b0, 3'b000, 32'h15, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 1'b0); wait_done();
        issue(1'b0, 3'b100, 32'h15, 32'h0, 32'h0000_00AA, 1'b0, 2, 1'b0); wait_done();
        issue(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_8899, 1'b0, 2, 1'b0); wait_done();
        issue(1'b0, 3'b101, 32'h16, 32'h0, 32'h0000_8899, 1'b0, 2, 1'b0); wait_done();
        chk("loads_no_write", wr_cnt - w0, 32'd0);

        // sub-word stores via read-modify-write
        w0 = wr_cnt;
        issue(1'b1, 3'b000, 32'h16, 32'h1234_56CC, 32'h0, 1'b0, 3, 1'b0); wait_done();
        chk("sb_write_count", wr_cnt - w0, 32'd1);
        chk("sb_ram5", ram[5], 32'h88CC_AABB);
        w0 = wr_cnt;
        issue(1'b1, 3'b001, 32'h14, 32'h0000_1234, 32'h0, 1'b0, 3, 1'b0); wait_done();
        chk("sh_write_count", wr_cnt - w0, 32'd1);
        chk("sh_ram5", ram[5], 32'h88CC_1234);

        // misaligned and illegal requests
        w0 = wr_cnt;
        issue(1'b0, 3'b010, 32'h15, 32'h0, 32'h0, 1'b1, 1, 1'b0); wait_done();
        issue(1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0); wait_done();
        issue(1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1, 1'b0); wait_done();
        chk("err_no_write", wr_cnt - w0, 32'd0);
        chk("err_ram5", ram[5], 32'h88CC_1234);
        repeat (2) @(negedge CLK);
        chk("err_held", {31'd0, resp_err}, 32'd1);

        // reset in the middle of a read-modify-write
        issue(1'b0, 3'b010, 32'h14, 32'h0, 32'h88CC_1234, 1'b0, 2, 1'b0); wait_done();
        w0 = wr_cnt;
        issue(1'b1, 3'b000, 32'h14, 32'h0000_0055, 32'h0, 1'b0, 3, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("abort_resp_rdata", resp_rdata, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_memwrite", {31'd0, mem_MemWrite}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        exp_q.delete();
        exp_err_q.delete();
        exp_lat_q.delete();
        acc_q.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("abort_ram5", ram[5], 32'h88CC_1234);
        chk("abort_no_write", wr_cnt - w0, 32'd0);

        // back-to-back with req_valid held high
        begin
            int a1;
            issue(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1);
            a1 = last_acc;
            issue(1'b0, 3'b010, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);
            chk("b2b_accept_gap", last_acc - a1, 32'd3);
            wait_done();
            chk("sw_ram0", ram[0], 32'hDEAD_BEEF);
        end

        // upper address bits alias onto word 0
        issue(1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);
        chk("alias_mem_address", {22'd0, mem_address}, 32'd0);
        wait_done();

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
